// File: rtl/debounce_multi_if.sv
// rtl/debounce_multi_if.sv - key bus between raw inputs and the debouncer outputs
interface debounce_multi_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] key_i;
   logic [CHANNELS-1:0] key_o;
   logic [CHANNELS-1:0] key_rise;
   logic [CHANNELS-1:0] key_fall;
   logic [CHANNELS-1:0] key_tog;

   // key source side: drives raw keys, observes the clean results
   modport master (
      output key_i,
      input  key_o,
      input  key_rise,
      input  key_fall,
      input  key_tog
   );

   // debouncer side
   modport slave (
      input  key_i,
      output key_o,
      output key_rise,
      output key_fall,
      output key_tog
   );
endinterface

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel key debouncer with edge pulses; toggle outputs under DEBOUNCE_TOGGLE_EN
module debounce_multi #(
   parameter int   CHANNELS      = 4,
   parameter int   STABLE_CYCLES = 1000,
   parameter int   CNT_W         = 24,
   parameter logic INIT_LEVEL    = 1'b0
) (
   input logic             clk,
   input logic             rst,
   debounce_multi_if.slave bus
);
   localparam logic [CNT_W-1:0]    STABLE_CNT = CNT_W'(STABLE_CYCLES);
   localparam logic [CHANNELS-1:0] INIT_VEC   = {CHANNELS{INIT_LEVEL}};

   logic [CHANNELS-1:0] sync1;
   logic [CHANNELS-1:0] sync2;
   logic [CHANNELS-1:0] key_m;
   logic [CHANNELS-1:0] key_lvl;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] stable_hit;
   logic [CNT_W-1:0]    cnt [CHANNELS];

   // two-flop synchroniser for the asynchronous key inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= INIT_VEC;
         sync2 <= INIT_VEC;
      end else begin
         sync1 <= bus.key_i;
         sync2 <= sync1;
      end
   end

   // sampled level tracking: any change restarts the count, a held level saturates it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_m <= INIT_VEC;
         for (int c = 0; c < CHANNELS; c++) begin
            cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (sync2[c] != key_m[c]) begin
               key_m[c] <= sync2[c];
               cnt[c]   <= '0;
            end else if (cnt[c] != STABLE_CNT) begin
               cnt[c] <= cnt[c] + CNT_W'(1);
            end
         end
      end
   end

   // a channel is accepted once its sampled level has held for the full count
   always_comb begin
      stable_hit = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         stable_hit[c] = (sync2[c] == key_m[c]) && (cnt[c] == STABLE_CNT);
      end
   end

   // clean level plus one-cycle edge pulses, all from the same acceptance decision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_lvl <= INIT_VEC;
         rise    <= '0;
         fall    <= '0;
      end else begin
         key_lvl <= (key_lvl & ~stable_hit) | (key_m & stable_hit);
         rise    <= stable_hit & key_m & ~key_lvl;
         fall    <= stable_hit & ~key_m & key_lvl;
      end
   end

   assign bus.key_o    = key_lvl;
   assign bus.key_rise = rise;
   assign bus.key_fall = fall;

`ifdef DEBOUNCE_TOGGLE_EN
   logic [CHANNELS-1:0] tog;

   // latch-style state flipped by each rise pulse, visible the cycle after it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tog <= '0;
      end else begin
         tog <= tog ^ rise;
      end
   end

   assign bus.key_tog = tog;
`else
   assign bus.key_tog = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi against a sample-history reference model
module tb_debounce_multi;
   localparam int CH = 4;
   localparam int S  = 8;

   typedef struct packed {
      logic [CH-1:0] o;
      logic [CH-1:0] rise;
      logic [CH-1:0] fall;
      logic [CH-1:0] tog;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   debounce_multi_if #(.CHANNELS(CH)) bus0 ();
   debounce_multi_if #(.CHANNELS(CH)) bus1 ();

   debounce_multi #(
      .CHANNELS(CH), .STABLE_CYCLES(S), .CNT_W(24), .INIT_LEVEL(1'b0)
   ) u_dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave)
   );

   debounce_multi #(
      .CHANNELS(CH), .STABLE_CYCLES(S), .CNT_W(24), .INIT_LEVEL(1'b1)
   ) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: key_o takes a level once the same level has been sampled
   // on S+2 consecutive edges, the newest of those being two edges old (sync delay).
   // A reset starts a fresh history of three INIT samples.
   exp_t          exp_q[$];
   logic [CH-1:0] hist[$];
   logic [CH-1:0] m_o;
   logic [CH-1:0] m_rise;
   logic [CH-1:0] m_tog;

   always @(posedge clk or posedge rst) begin
      exp_t          e;
      logic [CH-1:0] new_o;
      logic          same;
      if (rst) begin
         exp_q.delete();
         hist.delete();
         repeat (3) hist.push_back('0);
         m_o    = '0;
         m_rise = '0;
         m_tog  = '0;
      end else begin
         hist.push_back(bus0.key_i);
         if (hist.size() > S + 4) void'(hist.pop_front());
         new_o = m_o;
         if (hist.size() == S + 4) begin
            for (int c = 0; c < CH; c++) begin
               same = 1'b1;
               for (int j = 1; j <= S + 1; j++) begin
                  if (hist[j][c] != hist[0][c]) same = 1'b0;
               end
               if (same) new_o[c] = hist[0][c];
            end
         end
`ifdef DEBOUNCE_TOGGLE_EN
         e.tog = m_tog ^ m_rise;
`else
         e.tog = '0;
`endif
         e.rise = new_o & ~m_o;
         e.fall = ~new_o & m_o;
         e.o    = new_o;
         m_tog  = e.tog;
         m_rise = e.rise;
         m_o    = new_o;
         exp_q.push_back(e);
      end
   end

   // Monitor: one output set per cycle, compared away from the active edge
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         chk("rst_key_o", 32'(bus0.key_o), 32'(0));
         chk("rst_pulses", 32'({bus0.key_rise, bus0.key_fall, bus0.key_tog}), 32'(0));
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("key_o", 32'(bus0.key_o), 32'(e.o));
         chk("key_rise", 32'(bus0.key_rise), 32'(e.rise));
         chk("key_fall", 32'(bus0.key_fall), 32'(e.fall));
         chk("key_tog", 32'(bus0.key_tog), 32'(e.tog));
      end
      // INIT_LEVEL=1 instance with keys held high throughout: never any edge
      chk("init1_key_o", 32'(bus1.key_o), 32'(4'hF));
      chk("init1_pulses", 32'({bus1.key_rise, bus1.key_fall}), 32'(0));
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_immediate_key_o", 32'(bus0.key_o), 32'(0));
      chk("rst_immediate_pulses", 32'({bus0.key_rise, bus0.key_fall}), 32'(0));
      chk("rst_immediate_init1", 32'(bus1.key_o), 32'(4'hF));
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      int edges;
      int hold;
      rst        = 1'b1;
      bus0.key_i = '0;
      bus1.key_i = '1;
      step(3);
      @(posedge clk);
      #2 rst = 1'b0;
      step(S + 6);

      // single press: first sampling edge counts as 1, key_o follows S+3 edges later
      @(negedge clk);
      bus0.key_i[0] = 1'b1;
      edges = 0;
      while (edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (bus0.key_o[0]) break;
      end
      chk("latency_ch0", 32'(edges), 32'(1 + S + 3));
      step(4);

      // short glitch on ch1
      bus0.key_i[1] = 1'b1;
      step(5);
      bus0.key_i[1] = 1'b0;
      step(S + 8);

      // bounce on ch2 then held, then released
      for (int i = 0; i < 5; i++) begin
         bus0.key_i[2] = (i % 2 == 0);
         step(2);
      end
      step(S + 8);
      bus0.key_i[2] = 1'b0;
      step(S + 8);
      bus0.key_i[0] = 1'b0;
      step(S + 8);

      // all channels together, reset while debounced high, then mid-count reset
      bus0.key_i = '1;
      step(S + 8);
      do_reset();
      step(S + 8);
      bus0.key_i = '0;
      step(S + 8);
      bus0.key_i = '1;
      repeat (6) @(posedge clk);
      do_reset();
      step(S + 8);
      bus0.key_i = '0;
      step(S + 8);

      // three clean presses on ch3 for the toggle output
      for (int i = 0; i < 3; i++) begin
         bus0.key_i[3] = 1'b1;
         step(S + 6);
         bus0.key_i[3] = 1'b0;
         step(S + 6);
      end
`ifdef DEBOUNCE_TOGGLE_EN
      chk("tog_after_3_presses", 32'(bus0.key_tog[3]), 32'(1));
`else
      chk("tog_after_3_presses", 32'(bus0.key_tog[3]), 32'(0));
`endif

      // random holds of varied length, around the acceptance threshold
      for (int p = 0; p < 300; p++) begin
         bus0.key_i = CH'($urandom);
         hold = $urandom_range(1, S + 6);
         step(hold);
         if (p % 75 == 74) do_reset();
      end
      step(S + 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
